// File: rtl/riscboy_chip_core.sv
// RISCBoy test-chip core: a two-wire debug serial port drives a small register file
// controlling an async SRAM, bit-banged GPIO (boot flash), a parallel LCD port and PWM audio.
module riscboy_chip_core (
  input  logic        CLK,
  input  logic        RSTn,
  inout  wire         VDD,
  inout  wire         VSS,
  input  logic        DCK,
  inout  wire         DIO,
  inout  wire  [15:0] SRAM_DQ,
  output logic [16:0] SRAM_A,
  output logic        SRAM_OEn,
  output logic        SRAM_CSn,
  output logic        SRAM_WEn,
  output logic        AUDIO,
  output logic        LCD_CLK,
  output logic [7:0]  LCD_DAT,
  output logic        LCD_DC,
  output logic        LCD_BL,
  inout  wire  [3:0]  GPIO
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_WR, S_RD} state_t;
  state_t state, state_next;

  logic [2:0]  dck_sync;
  logic [1:0]  dio_sync;
  logic [3:0]  gpio_s1, gpio_in;
  logic        dck_rise, dck_fall, dio_bit, timeout;
  logic [9:0]  timer;
  logic [3:0]  bit_cnt;
  logic [7:0]  hdr_sr, reg_addr;
  logic [8:0]  hdr_full;
  logic [14:0] wr_sr;
  logic [15:0] wr_full, rd_sr, reg_rdata;
  logic        dio_oe, hdr_done, wr_done, rd_done;
  logic [16:0] sram_addr;
  logic [3:0]  gpio_out, gpio_oe;
  logic [7:0]  duty, pwm_cnt;
  logic        bl_reg;
  logic        sram_busy, sram_we, sram_wen;
  logic [1:0]  sram_cyc;
  logic [15:0] sram_wdata;
  logic        sram_capture, sram_wr_last;
  logic [1:0]  lcd_ph;
  logic        unused_pins;

  assign unused_pins = VDD ^ VSS;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dck_sync <= '0;
      dio_sync <= '0;
      gpio_s1  <= '0;
      gpio_in  <= '0;
    end else begin
      dck_sync <= {dck_sync[1:0], DCK};
      dio_sync <= {dio_sync[0], DIO};
      gpio_s1  <= GPIO;
      gpio_in  <= gpio_s1;
    end
  end

  assign dck_rise = dck_sync[1] & ~dck_sync[2];
  assign dck_fall = ~dck_sync[1] & dck_sync[2];
  assign dio_bit  = dio_sync[1];
  assign hdr_full = {hdr_sr, dio_bit};
  assign wr_full  = {wr_sr, dio_bit};
  // Expiry wins over a coincident DCK edge, so the bit is discarded.
  assign timeout  = (state != S_IDLE) && (timer == 10'h3FF);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (dck_rise && dio_bit) state_next = S_HDR;
      S_HDR:      if (dck_rise && bit_cnt == 4'd8) state_next = hdr_full[8] ? S_RD : S_WR;
      S_WR, S_RD: if (dck_rise && bit_cnt == 4'd15) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_IDLE;
  end

  always_comb begin
    hdr_done = (state == S_HDR) && dck_rise && (bit_cnt == 4'd8) && !timeout;
    wr_done  = (state == S_WR) && dck_rise && (bit_cnt == 4'd15) && !timeout;
    rd_done  = (state == S_RD) && dck_rise && (bit_cnt == 4'd15) && !timeout;
  end

  always_comb begin
    reg_rdata = 16'h0000;
    case (hdr_full[7:0])
      8'h00:   reg_rdata = sram_addr[15:0];
      8'h01:   reg_rdata = {15'h0, sram_addr[16]};
      8'h03:   reg_rdata = {12'h0, gpio_out};
      8'h04:   reg_rdata = {12'h0, gpio_oe};
      8'h05:   reg_rdata = {12'h0, gpio_in};
      8'h07:   reg_rdata = {15'h0, bl_reg};
      8'h08:   reg_rdata = {8'h0, duty};
      8'h0F:   reg_rdata = 16'h5242;
      default: reg_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      timer    <= '0;
      bit_cnt  <= '0;
      hdr_sr   <= '0;
      reg_addr <= '0;
      wr_sr    <= '0;
      rd_sr    <= '0;
      dio_oe   <= 1'b0;
    end else begin
      if (state == S_IDLE || dck_rise || dck_fall) timer <= '0;
      else                                         timer <= timer + 10'd1;
      if (state_next != state) bit_cnt <= '0;
      else if (dck_rise)       bit_cnt <= bit_cnt + 4'd1;
      if (state == S_HDR && dck_rise) hdr_sr <= hdr_full[7:0];
      if (hdr_done) reg_addr <= hdr_full[7:0];
      if (state == S_WR && dck_rise) wr_sr <= wr_full[14:0];
      // The first falling edge only enables the driver; later ones advance the shifter.
      if (hdr_done)                                   rd_sr <= reg_rdata;
      else if (sram_capture)                          rd_sr <= SRAM_DQ;
      else if (state == S_RD && dck_fall && dio_oe)   rd_sr <= {rd_sr[14:0], 1'b0};
      if (state_next == S_IDLE)                dio_oe <= 1'b0;
      else if (state == S_RD && dck_fall)      dio_oe <= 1'b1;
    end
  end

  assign DIO = dio_oe ? rd_sr[15] : 1'bz;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sram_addr <= '0;
      gpio_out  <= '0;
      gpio_oe   <= '0;
      bl_reg    <= 1'b0;
      duty      <= '0;
    end else begin
      if (wr_done) begin
        case (reg_addr)
          8'h00:   sram_addr[15:0] <= wr_full;
          8'h01:   sram_addr[16]   <= wr_full[0];
          8'h03:   gpio_out        <= wr_full[3:0];
          8'h04:   gpio_oe         <= wr_full[3:0];
          8'h07:   bl_reg          <= wr_full[0];
          8'h08:   duty            <= wr_full[7:0];
          default: ;
        endcase
      end
      if (sram_wr_last || (rd_done && reg_addr == 8'h02)) sram_addr <= sram_addr + 17'd1;
    end
  end

  assign sram_capture = sram_busy && !sram_we && (sram_cyc == 2'd3);
  assign sram_wr_last = sram_busy && sram_we && (sram_cyc == 2'd3);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sram_busy  <= 1'b0;
      sram_we    <= 1'b0;
      sram_wen   <= 1'b1;
      sram_cyc   <= '0;
      sram_wdata <= '0;
    end else if (wr_done && reg_addr == 8'h02) begin
      sram_busy  <= 1'b1;
      sram_we    <= 1'b1;
      sram_cyc   <= '0;
      sram_wdata <= wr_full;
    end else if (hdr_done && hdr_full[8] && hdr_full[7:0] == 8'h02) begin
      sram_busy <= 1'b1;
      sram_we   <= 1'b0;
      sram_cyc  <= '0;
    end else if (sram_busy) begin
      sram_cyc <= sram_cyc + 2'd1;
      if (sram_we && sram_cyc == 2'd0) sram_wen  <= 1'b0;
      if (sram_cyc == 2'd2)            sram_wen  <= 1'b1;
      if (sram_cyc == 2'd3)            sram_busy <= 1'b0;
    end
  end

  assign SRAM_A   = sram_addr;
  assign SRAM_CSn = ~sram_busy;
  assign SRAM_OEn = ~(sram_busy & ~sram_we);
  assign SRAM_WEn = sram_wen;
  assign SRAM_DQ  = (sram_busy && sram_we) ? sram_wdata : 16'hzzzz;

  // Phase 1 is data setup, phases 2-3 hold LCD_CLK high.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lcd_ph  <= '0;
      LCD_DAT <= '0;
      LCD_DC  <= 1'b0;
    end else if (wr_done && reg_addr == 8'h06) begin
      lcd_ph  <= 2'd1;
      LCD_DAT <= wr_full[7:0];
      LCD_DC  <= wr_full[8];
    end else if (lcd_ph != 2'd0) begin
      lcd_ph <= lcd_ph + 2'd1;
    end
  end

  assign LCD_CLK = lcd_ph[1];
  assign LCD_BL  = bl_reg;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pwm_cnt <= '0;
      AUDIO   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      AUDIO   <= (pwm_cnt < duty);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gpio
      assign GPIO[gi] = gpio_oe[gi] ? gpio_out[gi] : 1'bz;
    end
  endgenerate
endmodule

// File: tb/tb_riscboy_chip_core.sv
// Directed bench for riscboy_chip_core: bit-bangs the debug port and checks SRAM,
// GPIO/flash, LCD, audio, frame timeout and asynchronous reset abort.
`timescale 1ns/1ps
module tb_riscboy_chip_core;
  logic        clk = 1'b0, rst_n = 1'b0, dck = 1'b0;
  logic        host_drive = 1'b0, host_val = 1'b0;
  wire         dio, vdd, vss;
  wire  [15:0] sram_dq;
  wire  [3:0]  gpio;
  logic [16:0] sram_a;
  logic        sram_oen, sram_csn, sram_wen, audio, lcd_clk, lcd_dc, lcd_bl;
  logic [7:0]  lcd_dat;

  int total = 0, bad = 0;

  assign vdd = 1'b1;
  assign vss = 1'b0;
  assign dio = host_drive ? host_val : 1'bz;

  always #21 clk = ~clk;

  riscboy_chip_core dut (
    .CLK(clk), .RSTn(rst_n), .VDD(vdd), .VSS(vss), .DCK(dck), .DIO(dio),
    .SRAM_DQ(sram_dq), .SRAM_A(sram_a), .SRAM_OEn(sram_oen), .SRAM_CSn(sram_csn),
    .SRAM_WEn(sram_wen), .AUDIO(audio), .LCD_CLK(lcd_clk), .LCD_DAT(lcd_dat),
    .LCD_DC(lcd_dc), .LCD_BL(lcd_bl), .GPIO(gpio)
  );

  // Asynchronous SRAM model
  logic [15:0] sram_mem [0:131071];
  assign sram_dq = (!sram_csn && !sram_oen) ? sram_mem[sram_a] : 16'hzzzz;
  always @(posedge sram_wen) if (!sram_csn) sram_mem[sram_a] = sram_dq;

  // SPI flash model: answers 0x9F with JEDEC ID 0xEF4018 on IO1
  logic [7:0]  fl_cmd = 8'h00;
  int          fl_cnt = 0;
  logic [23:0] fl_resp = 24'hEF4018;
  logic        flash_io1 = 1'b0;
  assign gpio[3] = flash_io1;
  always @(posedge gpio[1]) if (!gpio[2]) begin
    if (fl_cnt < 8) fl_cmd = {fl_cmd[6:0], gpio[0]};
    fl_cnt++;
  end
  always @(negedge gpio[1]) if (!gpio[2] && fl_cnt >= 8 && fl_cmd == 8'h9F) begin
    flash_io1 = fl_resp[23];
    fl_resp   = {fl_resp[22:0], 1'b0};
  end

  // Strobe and LCD monitors, sampled on the falling clock edge
  int   wen_lo = 0, oen_lo = 0, csn_lo = 0, lcd_pulses = 0, lcd_high = 0, lcd_bad = 0;
  logic       lcd_clk_q = 1'b0;
  logic [8:0] lcd_word_q = 9'h0;
  always @(negedge clk) begin
    if (!sram_wen) wen_lo++;
    if (!sram_oen) oen_lo++;
    if (!sram_csn) csn_lo++;
    if (lcd_clk && !lcd_clk_q) begin
      lcd_pulses++;
      if (lcd_word_q !== 9'h1AB) lcd_bad++;
    end
    if (lcd_clk) begin
      lcd_high++;
      if ({lcd_dc, lcd_dat} !== 9'h1AB) lcd_bad++;
    end
    if (!lcd_clk && lcd_clk_q && {lcd_dc, lcd_dat} !== 9'h1AB) lcd_bad++;
    lcd_clk_q  = lcd_clk;
    lcd_word_q = {lcd_dc, lcd_dat};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    host_drive = 1'b1; host_val = b;
    tick(5); dck = 1'b1;
    tick(6); host_drive = 1'b0;
    tick(4); dck = 1'b0;
    tick(5);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    send_bit(1'b1); send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    for (int i = 15; i >= 0; i--) send_bit(d[i]);
    tick(10);
    $display("write addr=0x%02h data=0x%04h", a, d);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [15:0] d);
    d = 16'h0;
    send_bit(1'b1); send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    for (int i = 15; i >= 0; i--) begin
      tick(5); d[i] = dio; dck = 1'b1;
      tick(10); dck = 1'b0;
      tick(5);
    end
    tick(10);
    $display("read  addr=0x%02h data=0x%04h", a, d);
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  cmd, resp;
    logic [15:0] abort_data;
    logic        found;
    int          hi, w0, o0, c0, p0, h0, b0;
    cmd = 8'h9F; resp = 8'hEF; abort_data = 16'hBEEF;

    tick(5); rst_n = 1'b1; tick(3);
    check("rst_sram_a", sram_a, 0);
    check("rst_strobes", {sram_csn, sram_oen, sram_wen}, 3'b111);
    check("rst_audio_lcd_bl", {audio, lcd_clk, lcd_dc, lcd_bl}, 4'b0000);
    check("rst_lcd_dat", lcd_dat, 8'h00);
    read_reg(8'h0F, rd); check("id", rd, 16'h5242);

    // SRAM round trip across the 17-bit wrap
    w0 = wen_lo; o0 = oen_lo; c0 = csn_lo;
    write_reg(8'h01, 16'h0001); write_reg(8'h00, 16'hFFFF);
    write_reg(8'h02, 16'hA5C3); write_reg(8'h02, 16'h1234);
    check("mem_1ffff", sram_mem[17'h1FFFF], 16'hA5C3);
    check("mem_00000", sram_mem[17'h00000], 16'h1234);
    check("wr_wen_cycles", wen_lo - w0, 4);
    check("wr_csn_cycles", csn_lo - c0, 8);
    check("wr_oen_cycles", oen_lo - o0, 0);
    read_reg(8'h00, rd); check("addr_lo_after_wrap", rd, 16'h0001);
    read_reg(8'h01, rd); check("addr_hi_after_wrap", rd, 16'h0000);
    write_reg(8'h01, 16'h0001); write_reg(8'h00, 16'hFFFF);
    o0 = oen_lo;
    read_reg(8'h02, rd); check("rd_1ffff", rd, 16'hA5C3);
    read_reg(8'h02, rd); check("rd_00000", rd, 16'h1234);
    check("rd_oen_cycles", oen_lo - o0, 8);
    read_reg(8'h00, rd); check("addr_lo_after_rd", rd, 16'h0001);
    check("idle_strobes", {sram_csn, sram_oen, sram_wen}, 3'b111);

    // LCD pulse and backlight
    p0 = lcd_pulses; h0 = lcd_high; b0 = lcd_bad;
    write_reg(8'h06, 16'h01AB);
    check("lcd_pulses", lcd_pulses - p0, 1);
    check("lcd_high_cycles", lcd_high - h0, 2);
    check("lcd_stable", lcd_bad - b0, 0);
    check("lcd_hold", {lcd_dc, lcd_dat}, 9'h1AB);
    write_reg(8'h07, 16'h0001); check("lcd_bl", lcd_bl, 1'b1);

    // PWM audio
    write_reg(8'h08, 16'h0040); hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (audio) hi++; end
    check("audio_duty_40", hi, 64);
    write_reg(8'h08, 16'h00FF); hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (audio) hi++; end
    check("audio_duty_ff", hi, 255);
    write_reg(8'h08, 16'h0000); hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); if (audio) hi++; end
    check("audio_duty_00", hi, 0);

    // Flash JEDEC ID via bit-banged GPIO ([0] IO0, [1] SCK, [2] CSn, [3] IO1)
    write_reg(8'h03, 16'h0004); write_reg(8'h04, 16'h0007);
    write_reg(8'h03, 16'h0000);
    for (int i = 7; i >= 0; i--) begin
      write_reg(8'h03, {15'h0, cmd[i]});
      write_reg(8'h03, {14'h0, 1'b1, cmd[i]});
    end
    for (int i = 7; i >= 0; i--) begin
      write_reg(8'h03, 16'h0000);
      read_reg(8'h05, rd);
      check($sformatf("flash_id_bit%0d", i), rd, {12'h0, resp[i], 3'b000});
      write_reg(8'h03, 16'h0002);
    end

    // Abandoned frame: start + 5 bits, then silence longer than the timeout
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    tick(1100);
    write_reg(8'h03, 16'h0F00);
    read_reg(8'h03, rd); check("timeout_gpio_out", rd, 16'h0000);
    read_reg(8'h04, rd); check("timeout_gpio_oe", rd, 16'h0007);
    read_reg(8'h08, rd); check("timeout_duty", rd, 16'h0000);

    // Reset during an SRAM write must release the strobes without a clock
    send_bit(1'b1); send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(i == 1);
    for (int i = 15; i >= 1; i--) send_bit(abort_data[i]);
    host_drive = 1'b1; host_val = abort_data[0];
    tick(5); dck = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (!sram_csn) found = 1'b1;
    end
    check("abort_op_started", found, 1'b1);
    tick(1);
    check("abort_wen_low", sram_wen, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("abort_strobes", {sram_csn, sram_oen, sram_wen}, 3'b111);
    check("abort_lcd_bl", lcd_bl, 1'b0);
    host_drive = 1'b0; dck = 1'b0;
    tick(3); rst_n = 1'b1; tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscboy_chip_core.md
# riscboy_chip_core

Chip-level core of the RISCBoy test chip without the CPU. It bridges a two-wire debug serial port (DCK/DIO) to a small register file, which in turn drives a 16-bit asynchronous external SRAM, a 4-bit GPIO port used to bit-bang the SPI boot flash, an 8-bit parallel LCD port and a PWM audio output. It sits directly under the pad ring and is clocked by the 24 MHz board clock.

## Interface
- No parameters; widths fixed: N_SRAM_DQ=16, N_SRAM_A=17, N_GPIO=4.
- CLK  in  1  system clock, 24 MHz, the only clock
- RSTn  in  1  asynchronous active-low reset
- VDD, VSS  inout  1  supply pins, no logic
- DCK  in  1  debug serial clock, asynchronous to CLK
- DIO  inout  1  debug serial data
- SRAM_DQ  inout  16  SRAM data
- SRAM_A  out  17  SRAM word address
- SRAM_OEn / SRAM_CSn / SRAM_WEn  out  1 each  SRAM strobes, active low
- AUDIO  out  1  PWM audio
- LCD_CLK  out  1  LCD write strobe
- LCD_DAT  out  8  LCD data
- LCD_DC  out  1  LCD data/command
- LCD_BL  out  1  backlight enable
- GPIO  inout  4  GPIO; board wiring: [0] flash IO0, [1] SCK, [2] CSn, [3] IO1

## Operation
- Debug input: DCK and DIO pass through 2-flop synchronisers; DCK edges are detected in the CLK domain. DCK high and low phases must each last at least 8 CLK.
- Frame format, bits sampled on DCK rising edges, MSB first: start bit (1), RW (1 = read), ADDR[7:0]. Then:
  - Write: host sends DATA[15:0].
  - Read: the chip drives DIO with DATA[15:0]. Each bit is updated on a DCK falling edge, starting with the falling edge after the last ADDR bit. DIO is released after the 16th rising edge.
- When idle, bits of value 0 are ignored.
- If no DCK edge occurs for 1024 CLK, the frame is abandoned: return to idle, release DIO, no register side effect.
- Register map (unused bits read 0, unmapped addresses read 0 and ignore writes):
  - 0x00 ADDR_LO: SRAM address [15:0].
  - 0x01 ADDR_HI: bit 0 is SRAM address bit 16.
  - 0x02 DATA:
    - Write: performs an SRAM write, then the 17-bit address increments and wraps 0x1FFFF→0.
    - Read: the SRAM read is launched when ADDR completes, returns the SRAM word, then the address increments.
  - 0x03 GPIO_OUT [3:0]. 0x04 GPIO_OE [3:0]. 0x05 GPIO_IN [3:0], synchronised pin levels, read-only.
  - 0x06 LCD write: LCD_DAT=DATA[7:0] and LCD_DC=DATA[8], then one LCD_CLK pulse.
  - 0x07 BL: bit 0 drives LCD_BL.
  - 0x08 AUDIO duty [7:0].
  - 0x0F ID, read-only, value 0x5242.
- SRAM access takes 4 CLK cycles (c0–c3):
  - Address and SRAM_CSn=0 are asserted throughout.
  - Write: DQ is driven c0–c3, SRAM_WEn=0 in c1–c2.
  - Read: SRAM_OEn=0 in c0–c3, DQ is captured at the end of c3.
  - Idle: all strobes high, DQ high-Z.
- GPIO: pin n is driven with GPIO_OUT[n] when GPIO_OE[n]=1, otherwise high-Z.
- Audio: an 8-bit counter free-runs on CLK. AUDIO = (counter < duty). Duty 0 gives constant 0; duty 255 gives high for 255 of every 256 cycles.
- LCD pulse: data and DC are set up 1 CLK before LCD_CLK, LCD_CLK is high for 2 CLK, and data is held after the fall.

## Timing
- Reset values:
  - SRAM_A=0, all SRAM strobes 1, SRAM_DQ Z.
  - AUDIO=0, LCD_CLK=0, LCD_DAT=0, LCD_DC=0, LCD_BL=0.
  - GPIO Z (OE=0, OUT=0), DIO Z.
  - Address register 0, duty 0, frame state idle.
- A write's register side effect takes place within 2 CLK of the synchronised 16th data edge.
- SRAM and LCD operations complete in under 8 CLK, so back-to-back frames never overlap.
- A reset asserted during an SRAM or LCD operation aborts it immediately: strobes go high asynchronously.
- A DCK rising edge coinciding with the timeout expiry is treated as the timeout; the bit is discarded.

## Test plan
- Reset: after RSTn release, all outputs hold their reset values. A read of 0x0F returns 0x5242.
- SRAM round-trip: write ADDR_HI=1, ADDR_LO=0xFFFF, DATA=0xA5C3, DATA=0x1234 → SRAM words 0x1FFFF=0xA5C3 and 0x00000=0x1234 (address wraps). Readback from 0x1FFFF returns 0xA5C3, then 0x1234.
- Flash bit-bang: GPIO_OE=0x7, toggle SCK via GPIO_OUT while sending JEDEC ID command 0x9F → GPIO_IN[3] carries the model's response bits.
- LCD: write 0x1AB to 0x06 → exactly one LCD_CLK pulse with LCD_DAT=0xAB and LCD_DC=1 stable throughout.
- Audio: duty=0x40 → AUDIO high for 64 of every 256 CLK. Duty 0 → constantly low.
- Timeout: send a start bit plus 5 bits, idle for 1100 CLK, then a full write of 0x0F00 to 0x03 → GPIO_OUT=0x0 (bits [3:0] of the data), no spurious writes.
